// File: rtl/qam16_pkg.sv
// qam16_pkg: shared 16-QAM level/state encodings and symbol pack/unpack helpers
package qam16_pkg;
    localparam logic [1:0] LVL_P1 = 2'b00;
    localparam logic [1:0] LVL_P3 = 2'b01;
    localparam logic [1:0] LVL_M1 = 2'b10;
    localparam logic [1:0] LVL_M3 = 2'b11;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    function automatic logic [3:0] pack_pd(input logic [1:0] lvl_i, input logic [1:0] lvl_q);
        return {lvl_i[1], lvl_q[1], lvl_i[0], lvl_q[0]};
    endfunction
    function automatic logic [1:0] unpack_i(input logic [3:0] pd);
        return {pd[3], pd[1]};
    endfunction
    function automatic logic [1:0] unpack_q(input logic [3:0] pd);
        return {pd[2], pd[0]};
    endfunction
endpackage

// File: rtl/qam16_slicer.sv
// qam16_slicer: 4-level decision of one correlator sum against +/-2*energy, ties to the inner level
module qam16_slicer
    import qam16_pkg::*;
#(
    parameter int ACC_W = 41,
    parameter int EN_W = 36
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [EN_W-1:0]  energy,
    output logic        [1:0]       lvl
);
    logic signed [EN_W+2:0] t;
    logic signed [EN_W+2:0] nt;
    assign t = {2'b00, energy, 1'b0};
    assign nt = -t;
    assign lvl = acc[ACC_W-1] ? (acc < nt ? LVL_M3 : LVL_M1) : (acc > t ? LVL_P3 : LVL_P1);
endmodule

// File: rtl/qam16_demodulator.sv
// qam16_demodulator: coherent 16-QAM correlator receiver, one 4-bit symbol per SPS samples
module qam16_demodulator
    import qam16_pkg::*;
#(
    parameter int SPS = 16,
    parameter int CNT_W = $clog2(SPS),
    parameter int ACC_W = 37 + CNT_W,
    parameter int EN_W = 32 + CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sample_valid,
    input  logic signed [20:0] mixed_input,
    input  logic signed [15:0] sin,
    input  logic signed [15:0] cos,
    output logic        [3:0]  parallel_data,
    output logic               data_valid,
    output logic               busy
);
    logic [0:0] state;
    logic [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q, snap_i, snap_q;
    logic [EN_W-1:0] e_i, e_q, sum_ei, sum_eq, snap_ei, snap_eq;
    logic signed [36:0] prod_i, prod_q;
    logic [31:0] sq_i, sq_q;
    logic last, snap_pend;
    logic [1:0] lvl_i, lvl_q;

    assign prod_i = mixed_input * sin;
    assign prod_q = mixed_input * cos;
    assign sq_i = sin * sin;
    assign sq_q = cos * cos;
    assign sum_i = acc_i + ACC_W'(prod_i);
    assign sum_q = acc_q + ACC_W'(prod_q);
    assign sum_ei = e_i + EN_W'(sq_i);
    assign sum_eq = e_q + EN_W'(sq_q);
    assign last = cnt == CNT_W'(SPS - 1);
    assign busy = state == ST_RUN;

    // FSM, correlation over one symbol, and snapshot of the finished sums; start always wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            acc_i <= '0;
            acc_q <= '0;
            e_i <= '0;
            e_q <= '0;
            snap_i <= '0;
            snap_q <= '0;
            snap_ei <= '0;
            snap_eq <= '0;
            snap_pend <= 1'b0;
        end else begin
            snap_pend <= 1'b0;
            if (start) begin
                state <= ST_RUN;
                cnt <= '0;
                acc_i <= '0;
                acc_q <= '0;
                e_i <= '0;
                e_q <= '0;
            end else if (busy && sample_valid) begin
                cnt <= last ? '0 : cnt + 1'b1;
                acc_i <= last ? '0 : sum_i;
                acc_q <= last ? '0 : sum_q;
                e_i <= last ? '0 : sum_ei;
                e_q <= last ? '0 : sum_eq;
                if (last) begin
                    snap_i <= sum_i;
                    snap_q <= sum_q;
                    snap_ei <= sum_ei;
                    snap_eq <= sum_eq;
                    snap_pend <= 1'b1;
                end
            end
        end
    end

    qam16_slicer #(.ACC_W(ACC_W), .EN_W(EN_W)) u_slice_i (.acc(snap_i), .energy(snap_ei), .lvl(lvl_i));
    qam16_slicer #(.ACC_W(ACC_W), .EN_W(EN_W)) u_slice_q (.acc(snap_q), .energy(snap_eq), .lvl(lvl_q));

    // Register the sliced symbol one edge after the snapshot and strobe it once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parallel_data <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= snap_pend;
            if (snap_pend) parallel_data <= pack_pd(lvl_i, lvl_q);
        end
    end
endmodule

// File: tb/tb_qam16_demodulator.sv
// tb_qam16_demodulator: directed checks of the 16-QAM demodulator
module tb_qam16_demodulator;
    logic clk = 0, rst = 0, start = 0, sample_valid = 0;
    logic signed [20:0] mixed_input = 0;
    logic signed [15:0] sin_c = 0, cos_c = 0;
    logic [3:0] parallel_data;
    logic data_valid, busy;
    int checks = 0, errors = 0, cyc = 0, long_strobes = 0;
    logic prev_dv = 0;
    logic [3:0] pd_q[$];
    int cyc_q[$];
    int sin_tab[16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                        0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

    qam16_demodulator dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .mixed_input(mixed_input), .sin(sin_c), .cos(cos_c),
        .parallel_data(parallel_data), .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) begin
            pd_q.push_back(parallel_data);
            cyc_q.push_back(cyc);
        end
        if (data_valid && prev_dv) long_strobes++;
        prev_dv = data_valid;
    end

    function automatic int lvl(input logic [1:0] c);
        return c == 2'b00 ? 1 : c == 2'b01 ? 3 : c == 2'b10 ? -1 : -3;
    endfunction

    task automatic drive(input logic v, input int m, input int s, input int c);
        @(negedge clk);
        start = 0;
        sample_valid = v;
        mixed_input = 21'(m);
        sin_c = 16'(s);
        cos_c = 16'(c);
    endtask

    task automatic send_sample(input logic [3:0] pd, input int n);
        drive(1, lvl({pd[3], pd[1]}) * sin_tab[n] + lvl({pd[2], pd[0]}) * sin_tab[(n + 4) % 16],
              sin_tab[n], sin_tab[(n + 4) % 16]);
    endtask

    task automatic send_symbol(input logic [3:0] pd, input int nsamp);
        for (int n = 0; n < nsamp; n++) send_sample(pd, n);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        sample_valid = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (parallel_data !== 4'b0000) begin errors++; $display("FAIL reset_pd got %b want 0000", parallel_data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_idle();
        pd_q.delete();
        send_symbol(4'b0101, 16);
        idle_cycles(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        checks++; if (pd_q.size() !== 0) begin errors++; $display("FAIL idle_strobes got %0d want 0", pd_q.size()); end
    endtask

    task automatic test_all_symbols();
        pd_q.delete();
        pulse_start();
        for (int s = 0; s < 16; s++) send_symbol(4'(s), 16);
        idle_cycles(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy); end
        checks++; if (pd_q.size() !== 16) begin errors++; $display("FAIL all_count got %0d want 16", pd_q.size()); end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] got;
            got = i < pd_q.size() ? pd_q[i] : 4'bxxxx;
            checks++; if (got !== 4'(i)) begin errors++; $display("FAIL all_sym%0d got %b want %b", i, got, 4'(i)); end
        end
    endtask

    task automatic test_threshold_tie();
        logic [3:0] got;
        pd_q.delete();
        for (int n = 0; n < 16; n++) drive(1, 200, 100, 0);
        idle_cycles(4);
        got = pd_q.size() == 1 ? pd_q[0] : 4'bxxxx;
        checks++; if (got !== 4'b0000) begin errors++; $display("FAIL tie_inner got %b (n=%0d) want 0000", got, pd_q.size()); end
        pd_q.delete();
        for (int n = 0; n < 16; n++) drive(1, 201, 100, 0);
        idle_cycles(4);
        got = pd_q.size() == 1 ? pd_q[0] : 4'bxxxx;
        checks++; if (got !== 4'b0010) begin errors++; $display("FAIL tie_outer got %b (n=%0d) want 0010", got, pd_q.size()); end
    endtask

    task automatic test_gapped();
        int last_cyc;
        logic [3:0] got;
        int lat;
        pd_q.delete();
        cyc_q.delete();
        for (int n = 0; n < 16; n++) begin
            send_sample(4'b1111, n);
            last_cyc = cyc;
            drive(0, 99999, 1234, -1234);
        end
        idle_cycles(4);
        got = pd_q.size() == 1 ? pd_q[0] : 4'bxxxx;
        lat = cyc_q.size() == 1 ? cyc_q[0] - last_cyc : -1;
        checks++; if (got !== 4'b1111) begin errors++; $display("FAIL gap_pd got %b (n=%0d) want 1111", got, pd_q.size()); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL gap_latency got %0d want 2", lat); end
    endtask

    task automatic test_realign();
        logic [3:0] got;
        pd_q.delete();
        send_symbol(4'b0110, 5);
        pulse_start();
        send_symbol(4'b1001, 16);
        idle_cycles(4);
        checks++; if (pd_q.size() !== 1) begin errors++; $display("FAIL realign_count got %0d want 1", pd_q.size()); end
        got = pd_q.size() >= 1 ? pd_q[0] : 4'bxxxx;
        checks++; if (got !== 4'b1001) begin errors++; $display("FAIL realign_pd got %b want 1001", got); end
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        pd_q.delete();
        send_symbol(4'b0101, 16);
        @(posedge clk);
        #1 rst = 0;
        #1;
        checks++; if (parallel_data !== 4'b0000) begin errors++; $display("FAIL areset_pd got %b want 0000", parallel_data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL areset_dv got %b want 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        #2 rst = 1;
        idle_cycles(4);
        checks++; if (pd_q.size() !== 0) begin errors++; $display("FAIL areset_pending got %0d want 0", pd_q.size()); end
        send_symbol(4'b0011, 16);
        idle_cycles(3);
        checks++; if (pd_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL areset_idle got n=%0d busy=%b want 0 0", pd_q.size(), busy); end
        pulse_start();
        send_symbol(4'b1100, 16);
        idle_cycles(4);
        got = pd_q.size() == 1 ? pd_q[0] : 4'bxxxx;
        checks++; if (got !== 4'b1100) begin errors++; $display("FAIL areset_resume got %b (n=%0d) want 1100", got, pd_q.size()); end
    endtask

    task automatic test_strobe_width();
        checks++; if (long_strobes !== 0) begin errors++; $display("FAIL strobe_width got %0d long strobes want 0", long_strobes); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_all_symbols();
        test_threshold_tie();
        test_gapped();
        test_realign();
        test_async_reset();
        test_strobe_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
